touch_gesture_detector: RTL and testbench



---
 rtl/touch_pkg.sv | 22 ++
 rtl/touch_debounce.sv | 56 +++++
 rtl/touch_gesture_detector.sv | 132 +++++++++++++
 tb/tb_touch_gesture_detector.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared definitions for the touch gesture detector: FSM state encoding,
// default cycle counts for a 100 MHz clock and the counter width helper.
package touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT_GAP  = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HELD = 3'd4
    } gesture_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;    // 10 ms
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 100_000_000;  // 1 s
    localparam int unsigned DEF_DOUBLE_GAP_CYCLES = 30_000_000;   // 300 ms

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int TIMER_W(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/touch_debounce.sv
// Two-flop synchronizer and debounce counter for the raw touch level.
// The pressed port carries the level the debounced register takes on the
// next clock edge, so the parent can act on a debounced change in the
// same cycle the change is registered.
module touch_debounce
    import touch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic touched,
    output logic pressed
);

    localparam int CNT_W = TIMER_W(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count cycles of disagreement; adopt the new level once it has persisted.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer flops, debounce counter and debounced level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= touched;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = level_d;

endmodule

// File: rtl/touch_gesture_detector.sv
// Debounced touch level plus tap / double-tap / long-press classification.
// Event outputs are registered one-cycle pulses, set on the same edge as the
// FSM transition that produces them.
module touch_gesture_detector
    import touch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned DOUBLE_GAP_CYCLES = DEF_DOUBLE_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic touched,
    output logic pressed,
    output logic tap,
    output logic double_tap,
    output logic long_press
);

    localparam int unsigned TMAX = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                                   LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int TMR_W = TIMER_W(TMAX);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(DOUBLE_GAP_CYCLES - 1);

    logic             pressed_d;
    logic             pressed_q;
    gesture_state_e   state_q;
    gesture_state_e   state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             tap_q;
    logic             tap_d;
    logic             dtap_q;
    logic             dtap_d;
    logic             long_q;
    logic             long_d;
    logic             rise;
    logic             fall;
    logic             long_exp;
    logic             gap_exp;

    touch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .touched(touched),
        .pressed(pressed_d)
    );

    // Edges of the debounced level, seen on the edge that registers them.
    assign rise     = pressed_d & ~pressed_q;
    assign fall     = ~pressed_d & pressed_q;
    assign long_exp = (timer_q == LONG_LAST);
    assign gap_exp  = (timer_q == GAP_LAST);

    // Next-state, event pulses and shared timer.
    always_comb begin
        state_d = state_q;
        tap_d   = 1'b0;
        dtap_d  = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT_GAP;
                end else if (long_exp) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HELD;
                end
            end
            ST_WAIT_GAP: begin
                // A press landing exactly on gap expiry is too late to pair:
                // the first tap is reported and the press starts afresh.
                if (gap_exp) begin
                    tap_d   = 1'b1;
                    state_d = rise ? ST_PRESS1 : ST_IDLE;
                end else if (rise) begin
                    state_d = ST_PRESS2;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    dtap_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (long_exp) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_LONG_HELD)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State, timer, debounced output level and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pressed_q <= 1'b0;
            tap_q     <= 1'b0;
            dtap_q    <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pressed_q <= pressed_d;
            tap_q     <= tap_d;
            dtap_q    <= dtap_d;
            long_q    <= long_d;
        end
    end

    assign pressed    = pressed_q;
    assign tap        = tap_q;
    assign double_tap = dtap_q;
    assign long_press = long_q;

endmodule

// File: tb/tb_touch_gesture_detector.sv
// Directed bench for touch_gesture_detector with DEBOUNCE=4, LONG=40, GAP=12.
module tb_touch_gesture_detector;
    import touch_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 40;
    localparam int unsigned GAP  = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic touched;
    logic pressed;
    logic tap;
    logic double_tap;
    logic long_press;

    touch_gesture_detector #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .DOUBLE_GAP_CYCLES(GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .touched   (touched),
        .pressed   (pressed),
        .tap       (tap),
        .double_tap(double_tap),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    hold1;
        int    gap;
        int    hold2;      // 0: single press only
        int    rises;
        int    taps;
        int    dtaps;
        int    longs;
        int    rise_dly;   // first pressed rise minus drive edge, -1 = skip
        int    tap_dly;    // first tap minus first pressed fall, -1 = skip
        int    dtap_dly;   // first double_tap minus last pressed fall, -1 = skip
        int    long_dly;   // first long_press minus first pressed rise, -1 = skip
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    int   edge_n = 0;
    logic prev_pressed = 1'b0;
    int   n_rise, n_tap, n_dtap, n_long, n_multi = 0;
    int   t_rise, t_ffall, t_lfall, t_tap, t_dtap, t_long;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic clear_rec();
        n_rise = 0; n_tap = 0; n_dtap = 0; n_long = 0;
        t_rise = -1; t_ffall = -1; t_lfall = -1;
        t_tap = -1; t_dtap = -1; t_long = -1;
    endtask

    // Advance one clock and record what the outputs show just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (pressed && !prev_pressed) begin
            n_rise++;
            if (t_rise < 0) t_rise = edge_n;
        end
        if (!pressed && prev_pressed) begin
            if (t_ffall < 0) t_ffall = edge_n;
            t_lfall = edge_n;
        end
        prev_pressed = pressed;
        if (tap) begin n_tap++; if (t_tap < 0) t_tap = edge_n; end
        if (double_tap) begin n_dtap++; if (t_dtap < 0) t_dtap = edge_n; end
        if (long_press) begin n_long++; if (t_long < 0) t_long = edge_n; end
        if ((int'(tap) + int'(double_tap) + int'(long_press)) > 1) n_multi++;
    endtask

    task automatic run_vec(input vec_t v);
        int ref_e;
        clear_rec();
        touched = 1'b1;
        ref_e = edge_n;
        repeat (v.hold1) tick();
        touched = 1'b0;
        if (v.hold2 > 0) begin
            repeat (v.gap) tick();
            touched = 1'b1;
            repeat (v.hold2) tick();
            touched = 1'b0;
        end
        repeat (80) tick();
        chk({v.name, ".rises"}, n_rise, v.rises);
        chk({v.name, ".taps"},  n_tap,  v.taps);
        chk({v.name, ".dtaps"}, n_dtap, v.dtaps);
        chk({v.name, ".longs"}, n_long, v.longs);
        if (v.rise_dly >= 0) chk({v.name, ".rise_dly"}, t_rise - ref_e, v.rise_dly);
        if (v.tap_dly  >= 0) chk({v.name, ".tap_dly"},  t_tap - t_ffall, v.tap_dly);
        if (v.dtap_dly >= 0) chk({v.name, ".dtap_dly"}, t_dtap - t_lfall, v.dtap_dly);
        if (v.long_dly >= 0) chk({v.name, ".long_dly"}, t_long - t_rise, v.long_dly);
        chk({v.name, ".idle"}, int'(dut.state_q), int'(ST_IDLE));
    endtask

    vec_t vecs[6];

    initial begin
        int ref_e;

        vecs[0] = '{"glitch3", 3,  0,  0, 0, 0, 0, 0, -1, -1, -1, -1};
        vecs[1] = '{"tap10",   10, 0,  0, 1, 1, 0, 0,  6, 12, -1, -1};
        vecs[2] = '{"dtap",    10, 6,  10, 2, 0, 1, 0, 6, -1,  0, -1};
        vecs[3] = '{"long60",  60, 0,  0, 1, 0, 0, 1,  6, -1, -1, 40};
        vecs[4] = '{"gap11",   10, 11, 10, 2, 0, 1, 0, 6, -1,  0, -1};
        vecs[5] = '{"gap12",   10, 12, 10, 2, 2, 0, 0, 6, 12, -1, -1};

        rst_n   = 1'b0;
        touched = 1'b0;
        clear_rec();
        repeat (3) tick();
        chk("rst.pressed",    int'(pressed),    0);
        chk("rst.tap",        int'(tap),        0);
        chk("rst.double_tap", int'(double_tap), 0);
        chk("rst.long_press", int'(long_press), 0);
        chk("rst.state",      int'(dut.state_q), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Long press: pulse while still held, stays in LONG_HELD, silent release.
        clear_rec();
        touched = 1'b1;
        ref_e = edge_n;
        repeat (50) tick();
        chk("lp.count",   n_long, 1);
        chk("lp.at",      t_long - ref_e, 46);
        chk("lp.held",    int'(pressed), 1);
        chk("lp.state",   int'(dut.state_q), int'(ST_LONG_HELD));
        touched = 1'b0;
        repeat (20) tick();
        chk("lp.release_state", int'(dut.state_q), int'(ST_IDLE));
        chk("lp.release_pulses", n_tap + n_dtap + n_long, 1);

        // Reset during WAIT_GAP with touched held high through reset release.
        clear_rec();
        touched = 1'b1;
        repeat (10) tick();
        touched = 1'b0;
        repeat (12) tick();
        chk("rmid.in_gap", int'(dut.state_q), int'(ST_WAIT_GAP));
        touched = 1'b1;
        rst_n   = 1'b0;
        tick();
        chk("rmid.outs", int'({pressed, tap, double_tap, long_press}), 0);
        chk("rmid.state", int'(dut.state_q), int'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        ref_e = edge_n;
        clear_rec();
        repeat (30) tick();
        chk("rmid.no_tap",   n_tap + n_dtap + n_long, 0);
        chk("rmid.rise_dly", t_rise - ref_e, 6);
        chk("rmid.new_press", int'(dut.state_q), int'(ST_PRESS1));
        touched = 1'b0;
        repeat (60) tick();
        chk("rmid.later_tap", n_tap, 1);

        chk("onehot", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
